// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI responder.
// Frame width, bit counter width and FSM states.
package spi_pkg;

  localparam int DATA_W    = 16;
  localparam int BIT_CNT_W = 5;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous SPI line,
// with rise/fall strobes taken between ff2 and ff3.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_ff1;
  logic r_ff2;
  logic r_ff3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1 <= RST_VAL;
      r_ff2 <= RST_VAL;
      r_ff3 <= RST_VAL;
    end else begin
      r_ff1 <= i_async;
      r_ff2 <= r_ff1;
      r_ff3 <= r_ff2;
    end
  end

  assign o_sync = r_ff2;
  assign o_rise = r_ff2 & ~r_ff3;
  assign o_fall = ~r_ff2 & r_ff3;

endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI responder: SS_n frames, SCLK idles high, MSB first.
// MOSI sampled on SCLK fall, shifted in on rise; MISO is shft MSB.
module spi_slv16
  import spi_pkg::*;
#(
  parameter int DATA_W = spi_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              wrt,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  input  logic              clr_rdy,
  output logic              frm_err
);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_sclk_lvl_unused;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_ss_lvl_unused;

  logic r_mosi_ff1;
  logic r_mosi_ff2;
  logic r_mosi_ff3_unused;
  logic r_mosi_smpl;

  spi_slv_state_t       r_state;
  logic [DATA_W-1:0]    r_shft;
  logic [DATA_W-1:0]    r_tx_buf;
  logic [DATA_W-1:0]    r_rx_data;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_rdy;
  logic                 r_frm_err;

  logic [DATA_W-1:0]    w_shft_nxt;
  logic [BIT_CNT_W-1:0] w_cnt_nxt;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SCLK),
    .o_sync (w_sclk_lvl_unused),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SS_n),
    .o_sync (w_ss_lvl_unused),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_ff1        <= 1'b0;
      r_mosi_ff2        <= 1'b0;
      r_mosi_ff3_unused <= 1'b0;
    end else begin
      r_mosi_ff1        <= MOSI;
      r_mosi_ff2        <= r_mosi_ff1;
      r_mosi_ff3_unused <= r_mosi_ff2;
    end
  end

  // SCLK edge is applied before an SS_n rise in the same cycle
  always_comb begin
    w_shft_nxt = r_shft;
    w_cnt_nxt  = r_bit_cnt;
    if (w_sclk_rise) begin
      w_shft_nxt = {r_shft[DATA_W-2:0], r_mosi_smpl};
      if (r_bit_cnt != '1) w_cnt_nxt = r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shft      <= '0;
      r_tx_buf    <= '0;
      r_rx_data   <= '0;
      r_bit_cnt   <= '0;
      r_rdy       <= 1'b0;
      r_frm_err   <= 1'b0;
      r_mosi_smpl <= 1'b0;
    end else begin
      if (wrt) r_tx_buf <= tx_data;
      if (clr_rdy) begin
        r_rdy     <= 1'b0;
        r_frm_err <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_shft    <= wrt ? tx_data : r_tx_buf;
            r_bit_cnt <= '0;
            r_state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          r_shft    <= w_shft_nxt;
          r_bit_cnt <= w_cnt_nxt;
          if (w_sclk_fall) r_mosi_smpl <= r_mosi_ff2;
          if (w_ss_rise) begin
            r_state <= IDLE;
            if (w_cnt_nxt == BIT_CNT_W'(DATA_W)) begin
              r_rx_data <= w_shft_nxt;
              r_rdy     <= 1'b1;
            end else begin
              r_frm_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MISO    = r_shft[DATA_W-1];
  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;

endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: behavioural SPI master plus a
// frame-level model of the responder's sticky state.
module tb_spi_slv16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] tx_data;
  logic        wrt;
  logic [15:0] rx_data;
  logic        rdy;
  logic        clr_rdy;
  logic        frm_err;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_tx;
  logic [15:0] m_rx;
  logic        m_rdy;
  logic        m_err;

  always #5 clk = ~clk;

  spi_slv16 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .tx_data(tx_data),
    .wrt    (wrt),
    .rx_data(rx_data),
    .rdy    (rdy),
    .clr_rdy(clr_rdy),
    .frm_err(frm_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_wrt(input logic [15:0] v);
    tx_data = v;
    wrt     = 1'b1;
    tick(1);
    wrt     = 1'b0;
    m_tx    = v;
  endtask

  task automatic do_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    m_rdy   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_rx"},  32'(rx_data), 32'(m_rx));
    chk({tag, "_rdy"}, 32'(rdy),     32'(m_rdy));
    chk({tag, "_err"}, 32'(frm_err), 32'(m_err));
  endtask

  // Master side: nb SCLK pulses, MISO read 2 clks after each rise
  task automatic frame(input logic [15:0] d, input int nb,
                       input bit raise, input bit mwrt,
                       input logic [15:0] wv, input bit clr_end,
                       output logic [15:0] rd);
    rd   = '0;
    SS_n = 1'b0;
    tick(8);
    for (int k = 0; k < nb; k++) begin
      MOSI = (k < 16) ? d[15-k] : 1'($urandom);
      if (mwrt && k == 8) begin
        tx_data = wv;
        wrt     = 1'b1;
        tick(1);
        wrt     = 1'b0;
        tick(3);
      end else begin
        tick(4);
      end
      SCLK = 1'b0;
      tick(8);
      SCLK = 1'b1;
      tick(2);
      if (k < 16) rd[15-k] = MISO;
      tick(2);
    end
    tick(4);
    if (raise) begin
      SS_n = 1'b1;
      if (clr_end) begin
        tick(2);
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        tick(5);
      end else begin
        tick(8);
      end
    end
  endtask

  // Full frame plus model update and checks
  task automatic run_frame(input string tag, input logic [15:0] d,
                           input int nb, input bit mwrt,
                           input logic [15:0] wv, input bit clr_end);
    logic [15:0] rd;
    logic [15:0] exp_rd;
    exp_rd = m_tx;
    frame(d, nb, 1'b1, mwrt, wv, clr_end, rd);
    if (mwrt) m_tx = wv;
    if (clr_end) begin
      m_rdy = 1'b0;
      m_err = 1'b0;
    end
    if (nb == 16) begin
      m_rx  = d;
      m_rdy = 1'b1;
    end else begin
      m_err = 1'b1;
    end
    if (nb == 16) chk({tag, "_miso"}, 32'(rd), 32'(exp_rd));
    chk_outs(tag);
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] d;
    int          nb;
    rst_n   = 1'b0;
    SS_n    = 1'b0;
    SCLK    = 1'b1;
    MOSI    = 1'b0;
    tx_data = '0;
    wrt     = 1'b0;
    clr_rdy = 1'b0;
    m_tx = '0; m_rx = '0; m_rdy = 1'b0; m_err = 1'b0;
    tick(3);
    chk("rst_miso", 32'(MISO), 32'h0);
    chk_outs("rst");
    rst_n = 1'b1;
    tick(1);

    run_frame("first", 16'(($urandom)), 16, 1'b0, '0, 1'b0);
    do_clr();

    do_wrt(16'hA5C3);
    frame(16'h1234, 16, 1'b0, 1'b0, '0, 1'b0, rd);
    SS_n = 1'b1;
    tick(2);
    chk("t2_rdy_early", 32'(rdy), 32'h0);
    tick(1);
    chk("t2_rdy_3clk", 32'(rdy), 32'h1);
    chk("t2_miso", 32'(rd), 32'hA5C3);
    m_rx = 16'h1234; m_rdy = 1'b1;
    chk_outs("t2");
    tick(5);

    run_frame("ffff", 16'hFFFF, 16, 1'b0, '0, 1'b0);
    run_frame("zero", 16'h0000, 16, 1'b0, '0, 1'b0);
    run_frame("clrset", 16'h5A3C, 16, 1'b0, '0, 1'b1);

    run_frame("short5", 16'hC0DE, 5, 1'b0, '0, 1'b0);
    do_clr();
    chk_outs("clr_err");

    do_wrt(16'h7E81);
    frame(16'h9999, 8, 1'b0, 1'b0, '0, 1'b0, rd);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    tick(2);
    m_tx = '0; m_rx = '0; m_rdy = 1'b0; m_err = 1'b0;
    chk("midrst_miso", 32'(MISO), 32'h0);
    chk_outs("midrst");
    rst_n = 1'b1;
    tick(4);
    run_frame("beef", 16'hBEEF, 16, 1'b0, '0, 1'b0);

    run_frame("midwrt", 16'h1111, 16, 1'b1, 16'h0F0F, 1'b0);
    run_frame("after_wrt", 16'h2222, 16, 1'b0, '0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) do_wrt(16'($urandom));
      if ($urandom_range(0, 3) == 0) do_clr();
      d  = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 16;
      run_frame("rnd", d, nb, 1'b0, '0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
